// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: state encoding, widths and the bubble instruction.
package fetch_stage_pkg;

    localparam int ADDR_W  = 32;
    localparam int INSTR_W = 32;

    // sll $0,$0,0
    localparam logic [INSTR_W-1:0] NOP_INSTR_C = '0;
    localparam logic [ADDR_W-1:0]  PC_STEP     = 32'd4;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Enable/flush pipeline register carrying {PC+4, instruction, valid}.
// Flush wins over enable and leaves PC+4 untouched, since a bubble's PC is meaningless.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en_i,
    input  logic               flush_i,
    input  logic [ADDR_W-1:0]  pc4_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               valid_i,
    output logic [ADDR_W-1:0]  pc4_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o
);

    logic [ADDR_W-1:0]  pc4_q;
    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc4_q   <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (en_i) begin
            pc4_q   <= pc4_i;
            instr_q <= instr_i;
            valid_q <= valid_i;
        end
    end

    assign pc4_o   = pc4_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, runs the imem req/ready handshake
// and feeds the IF/ID register, honouring hazard stalls and ID redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PC_Write,
    input  logic               IF_ID_Write,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  Redirect_PC,
    output logic               Imem_Req,
    output logic [ADDR_W-1:0]  Imem_Addr,
    input  logic [INSTR_W-1:0] Imem_Rdata,
    input  logic               Imem_Ready,
    output logic [ADDR_W-1:0]  IF_ID_PC4,
    output logic [INSTR_W-1:0] IF_ID_Instr,
    output logic               IF_ID_Valid,
    output logic               Fetch_Stall
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  old_addr_q, old_addr_d;
    logic [INSTR_W-1:0] buf_q, buf_d;

    logic               stall;
    logic               ld_en;
    logic               ld_flush;
    logic [INSTR_W-1:0] ld_instr;
    logic               stall_bubble;

    assign stall = !PC_Write || !IF_ID_Write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            old_addr_q <= '0;
            buf_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            old_addr_q <= old_addr_d;
            buf_q      <= buf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        old_addr_d   = old_addr_q;
        buf_d        = buf_q;
        ld_en        = 1'b0;
        ld_flush     = 1'b0;
        ld_instr     = Imem_Rdata;
        stall_bubble = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (Redirect) begin
                    pc_d     = Redirect_PC;
                    ld_flush = 1'b1;
                    // An outstanding request cannot be cancelled, so wait it out
                    if (!Imem_Ready) begin
                        old_addr_d = pc_q;
                        state_d    = ST_DRAIN;
                    end
                end else if (Imem_Ready) begin
                    if (stall) begin
                        buf_d   = Imem_Rdata;
                        state_d = ST_HOLD;
                    end else begin
                        ld_en = 1'b1;
                        pc_d  = next_pc(pc_q);
                    end
                end else if (!stall) begin
                    ld_flush     = 1'b1;
                    stall_bubble = 1'b1;
                end
            end
            ST_HOLD: begin
                if (Redirect) begin
                    pc_d     = Redirect_PC;
                    ld_flush = 1'b1;
                    state_d  = ST_FETCH;
                end else if (!stall) begin
                    ld_en    = 1'b1;
                    ld_instr = buf_q;
                    pc_d     = next_pc(pc_q);
                    state_d  = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (Imem_Ready) begin
                    state_d = ST_FETCH;
                end
                if (Redirect) begin
                    pc_d     = Redirect_PC;
                    ld_flush = 1'b1;
                end else if (!stall) begin
                    ld_flush     = 1'b1;
                    stall_bubble = 1'b1;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign Imem_Req    = rst_n && (state_q != ST_HOLD);
    assign Imem_Addr   = (state_q == ST_DRAIN) ? old_addr_q : pc_q;
    assign Fetch_Stall = rst_n && stall_bubble;

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (ld_en),
        .flush_i (ld_flush),
        .pc4_i   (next_pc(pc_q)),
        .instr_i (ld_instr),
        .valid_i (1'b1),
        .pc4_o   (IF_ID_PC4),
        .instr_o (IF_ID_Instr),
        .valid_o (IF_ID_Valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run,
// all compared against a transaction-level model of the fetch rules.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PC_Write, IF_ID_Write, Redirect;
    logic [31:0] Redirect_PC;
    logic        Imem_Req;
    logic [31:0] Imem_Addr;
    logic [31:0] Imem_Rdata;
    logic        Imem_Ready;
    logic [31:0] IF_ID_PC4;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_Valid;
    logic        Fetch_Stall;

    int total = 0;
    int bad   = 0;

    // Reference model: architectural PC, an optional held word, an optional draining address
    logic [31:0] m_pc, m_old, m_word;
    logic        m_drain, m_held;
    logic [31:0] e_pc4, e_instr;
    logic        e_valid;
    // Expected combinational outputs for the current cycle
    logic [31:0] e_addr;
    logic        e_req, e_fst;
    // Inputs applied this cycle
    logic        c_pcw, c_ifw, c_rd, c_rdy;
    logic [31:0] c_rpc, c_rdata;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PC_Write    (PC_Write),
        .IF_ID_Write (IF_ID_Write),
        .Redirect    (Redirect),
        .Redirect_PC (Redirect_PC),
        .Imem_Req    (Imem_Req),
        .Imem_Addr   (Imem_Addr),
        .Imem_Rdata  (Imem_Rdata),
        .Imem_Ready  (Imem_Ready),
        .IF_ID_PC4   (IF_ID_PC4),
        .IF_ID_Instr (IF_ID_Instr),
        .IF_ID_Valid (IF_ID_Valid),
        .Fetch_Stall (Fetch_Stall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0; m_old = 32'h0; m_word = 32'h0;
        m_drain = 1'b0; m_held = 1'b0;
        e_pc4 = 32'h0; e_instr = 32'h0; e_valid = 1'b0;
    endtask

    task automatic model_step();
        logic stall;
        stall = !(c_pcw && c_ifw);
        if (c_rd) begin
            e_valid = 1'b0; e_instr = 32'h0;
            m_pc    = c_rpc;
            if (m_held)       m_held = 1'b0;
            else if (m_drain) m_drain = !c_rdy;
            else if (!c_rdy) begin m_drain = 1'b1; m_old = e_addr; end
        end else if (m_held) begin
            if (!stall) begin
                e_pc4 = m_pc + 32'd4; e_instr = m_word; e_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_held = 1'b0;
            end
        end else if (m_drain) begin
            if (c_rdy) m_drain = 1'b0;
            if (!stall) begin e_valid = 1'b0; e_instr = 32'h0; end
        end else if (c_rdy) begin
            if (stall) begin
                m_held = 1'b1; m_word = c_rdata;
            end else begin
                e_pc4 = m_pc + 32'd4; e_instr = c_rdata; e_valid = 1'b1;
                m_pc = m_pc + 32'd4;
            end
        end else if (!stall) begin
            e_valid = 1'b0; e_instr = 32'h0;
        end
    endtask

    // Applies inputs at posedge+1 and returns just before the falling edge
    task automatic drive(input logic pcw, input logic ifw, input logic rd,
                         input logic [31:0] rpc, input logic rdy);
        c_pcw = pcw; c_ifw = ifw; c_rd = rd; c_rpc = rpc; c_rdy = rdy;
        e_addr  = m_drain ? m_old : m_pc;
        e_req   = !m_held;
        e_fst   = !rd && pcw && ifw && (m_drain || (!m_held && !rdy));
        c_rdata = mem_word(e_addr);
        PC_Write = pcw; IF_ID_Write = ifw; Redirect = rd; Redirect_PC = rpc;
        Imem_Ready = rdy;
        Imem_Rdata = rdy ? c_rdata : 32'hDEAD_BEEF;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        PC_Write = 1'b1; IF_ID_Write = 1'b1; Redirect = 1'b0;
        Redirect_PC = 32'h0; Imem_Ready = 1'b0; Imem_Rdata = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (Imem_Req !== 1'b0 || Fetch_Stall !== 1'b0 || IF_ID_Valid !== 1'b0 ||
            IF_ID_Instr !== 32'h0 || IF_ID_PC4 !== 32'h0) begin
            bad++;
            $display("FAIL reset_state req=%b fst=%b valid=%b instr=%h pc4=%h want 0 0 0 00000000 00000000",
                     Imem_Req, Fetch_Stall, IF_ID_Valid, IF_ID_Instr, IF_ID_PC4);
        end
        rst_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_zero_wait();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 32'h0, 1);
            total++;
            if (Imem_Addr !== 32'(4 * i) || Imem_Req !== 1'b1) begin
                bad++;
                $display("FAIL zero_wait_addr i=%0d addr=%h req=%b want %h 1", i, Imem_Addr, Imem_Req, 32'(4 * i));
            end
            tick();
            total++;
            if (IF_ID_PC4 !== 32'(4 * i + 4) || IF_ID_Valid !== 1'b1 || IF_ID_Instr !== mem_word(32'(4 * i))) begin
                bad++;
                $display("FAIL zero_wait_ifid i=%0d pc4=%h valid=%b instr=%h want %h 1 %h",
                         i, IF_ID_PC4, IF_ID_Valid, IF_ID_Instr, 32'(4 * i + 4), mem_word(32'(4 * i)));
            end
            $display("zero_wait: addr=%h pc4=%h", Imem_Addr, IF_ID_PC4);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] p0;
        p0 = m_pc;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 32'h0, i == 2);
            total++;
            if (Imem_Addr !== p0 || Fetch_Stall !== (i != 2)) begin
                bad++;
                $display("FAIL wait_comb i=%0d addr=%h fst=%b want %h %b", i, Imem_Addr, Fetch_Stall, p0, i != 2);
            end
            tick();
            total++;
            if (IF_ID_Valid !== (i == 2) || (i == 2 && IF_ID_PC4 !== p0 + 32'd4)) begin
                bad++;
                $display("FAIL wait_ifid i=%0d valid=%b pc4=%h want %b %h", i, IF_ID_Valid, IF_ID_PC4, i == 2, p0 + 32'd4);
            end
            $display("wait_states: i=%0d valid=%b pc4=%h", i, IF_ID_Valid, IF_ID_PC4);
        end
    endtask

    task automatic test_stall_hold();
        logic [31:0] p0, h_pc4, h_instr;
        p0 = m_pc; h_pc4 = IF_ID_PC4; h_instr = IF_ID_Instr;
        for (int i = 0; i < 3; i++) begin
            // the middle cycle stalls with only IF_ID_Write low
            drive(i == 1, 1'b0, 0, 32'h0, 1);
            total++;
            if (Imem_Req !== (i == 0) || Imem_Addr !== p0) begin
                bad++;
                $display("FAIL hold_req i=%0d req=%b addr=%h want %b %h", i, Imem_Req, Imem_Addr, i == 0, p0);
            end
            tick();
            total++;
            if (IF_ID_PC4 !== h_pc4 || IF_ID_Instr !== h_instr || IF_ID_Valid !== 1'b1) begin
                bad++;
                $display("FAIL hold_ifid i=%0d pc4=%h instr=%h valid=%b want %h %h 1",
                         i, IF_ID_PC4, IF_ID_Instr, IF_ID_Valid, h_pc4, h_instr);
            end
        end
        drive(1, 1, 0, 32'h0, 0);
        tick();
        total++;
        if (IF_ID_PC4 !== p0 + 32'd4 || IF_ID_Instr !== mem_word(p0) || IF_ID_Valid !== 1'b1) begin
            bad++;
            $display("FAIL hold_release pc4=%h instr=%h valid=%b want %h %h 1",
                     IF_ID_PC4, IF_ID_Instr, IF_ID_Valid, p0 + 32'd4, mem_word(p0));
        end
        drive(1, 1, 0, 32'h0, 1);
        total++;
        if (Imem_Addr !== p0 + 32'd4 || Imem_Req !== 1'b1) begin
            bad++;
            $display("FAIL hold_next_addr addr=%h req=%b want %h 1", Imem_Addr, Imem_Req, p0 + 32'd4);
        end
        tick();
        $display("stall_hold: released pc4=%h", IF_ID_PC4);
    endtask

    task automatic test_redirect_drain();
        logic [31:0] p0;
        p0 = m_pc;
        drive(1, 1, 1, 32'h100, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 0, 32'h0, i == 1);
            total++;
            if (Imem_Addr !== p0 || Imem_Req !== 1'b1 || Fetch_Stall !== 1'b1) begin
                bad++;
                $display("FAIL drain_comb i=%0d addr=%h req=%b fst=%b want %h 1 1", i, Imem_Addr, Imem_Req, Fetch_Stall, p0);
            end
            tick();
            total++;
            if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 32'h0) begin
                bad++;
                $display("FAIL drain_bubble i=%0d valid=%b instr=%h want 0 00000000", i, IF_ID_Valid, IF_ID_Instr);
            end
        end
        drive(1, 1, 0, 32'h0, 1);
        total++;
        if (Imem_Addr !== 32'h100) begin
            bad++;
            $display("FAIL drain_target addr=%h want 00000100", Imem_Addr);
        end
        tick();
        total++;
        if (IF_ID_Valid !== 1'b1 || IF_ID_PC4 !== 32'h104) begin
            bad++;
            $display("FAIL drain_first valid=%b pc4=%h want 1 00000104", IF_ID_Valid, IF_ID_PC4);
        end
        $display("redirect_drain: pc4=%h", IF_ID_PC4);
    endtask

    task automatic test_redirect_hold();
        drive(0, 0, 0, 32'h0, 1);
        tick();
        drive(0, 0, 1, 32'h40, 1);
        tick();
        total++;
        if (IF_ID_Valid !== 1'b0 || IF_ID_Instr !== 32'h0) begin
            bad++;
            $display("FAIL redir_hold_bubble valid=%b instr=%h want 0 00000000", IF_ID_Valid, IF_ID_Instr);
        end
        drive(1, 1, 0, 32'h0, 1);
        total++;
        if (Imem_Addr !== 32'h40 || Imem_Req !== 1'b1) begin
            bad++;
            $display("FAIL redir_hold_addr addr=%h req=%b want 00000040 1", Imem_Addr, Imem_Req);
        end
        tick();
        total++;
        if (IF_ID_PC4 !== 32'h44 || IF_ID_Instr !== mem_word(32'h40)) begin
            bad++;
            $display("FAIL redir_hold_ifid pc4=%h instr=%h want 00000044 %h", IF_ID_PC4, IF_ID_Instr, mem_word(32'h40));
        end
        $display("redirect_hold: pc4=%h", IF_ID_PC4);
    endtask

    task automatic test_wrap();
        drive(1, 1, 1, 32'hFFFF_FFFC, 1);
        tick();
        drive(1, 1, 0, 32'h0, 1);
        tick();
        total++;
        if (IF_ID_PC4 !== 32'h0 || IF_ID_Valid !== 1'b1) begin
            bad++;
            $display("FAIL wrap_pc4 pc4=%h valid=%b want 00000000 1", IF_ID_PC4, IF_ID_Valid);
        end
        drive(1, 1, 1, 32'h0000_0203, 1);
        tick();
        drive(1, 1, 0, 32'h0, 1);
        total++;
        if (Imem_Addr !== 32'h0000_0203) begin
            bad++;
            $display("FAIL unaligned_addr addr=%h want 00000203", Imem_Addr);
        end
        tick();
        total++;
        if (IF_ID_PC4 !== 32'h0000_0207) begin
            bad++;
            $display("FAIL unaligned_pc4 pc4=%h want 00000207", IF_ID_PC4);
        end
        $display("wrap: pc4=%h", IF_ID_PC4);
    endtask

    task automatic test_random();
        logic pcw, ifw, rd, rdy;
        logic [31:0] rpc;
        for (int i = 0; i < 400; i++) begin
            pcw = ($urandom_range(99) >= 20);
            ifw = ($urandom_range(99) < 90) ? pcw : !pcw;
            rd  = ($urandom_range(99) < 10);
            rdy = ($urandom_range(99) < 70);
            rpc = {$urandom_range(32'hFFFF), 14'h0, 2'($urandom_range(3))} ;
            if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
            drive(pcw, ifw, rd, rpc, rdy);
            total++;
            if (Imem_Addr !== e_addr || Imem_Req !== e_req || Fetch_Stall !== e_fst) begin
                bad++;
                $display("FAIL rand_comb i=%0d addr=%h req=%b fst=%b want %h %b %b",
                         i, Imem_Addr, Imem_Req, Fetch_Stall, e_addr, e_req, e_fst);
            end
            tick();
            total++;
            if (IF_ID_Valid !== e_valid || IF_ID_Instr !== e_instr || (e_valid && IF_ID_PC4 !== e_pc4)) begin
                bad++;
                $display("FAIL rand_ifid i=%0d valid=%b instr=%h pc4=%h want %b %h %h",
                         i, IF_ID_Valid, IF_ID_Instr, IF_ID_PC4, e_valid, e_instr, e_pc4);
            end
            $display("random: i=%0d pcw=%b ifw=%b rd=%b rdy=%b addr=%h valid=%b pc4=%h",
                     i, pcw, ifw, rd, rdy, Imem_Addr, IF_ID_Valid, IF_ID_PC4);
        end
    endtask

    task automatic test_reset_in_drain();
        drive(1, 1, 0, 32'h0, 1);
        tick();
        drive(1, 1, 1, 32'h300, 0);
        tick();
        drive(1, 1, 0, 32'h0, 0);
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (Imem_Req !== 1'b0 || Fetch_Stall !== 1'b0 || IF_ID_Valid !== 1'b0 ||
            IF_ID_Instr !== 32'h0 || IF_ID_PC4 !== 32'h0 || Imem_Addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_async req=%b fst=%b valid=%b instr=%h pc4=%h addr=%h want all zero",
                     Imem_Req, Fetch_Stall, IF_ID_Valid, IF_ID_Instr, IF_ID_PC4, Imem_Addr);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(1, 1, 0, 32'h0, 1);
        total++;
        if (Imem_Addr !== 32'h0 || Imem_Req !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_addr addr=%h req=%b want 00000000 1", Imem_Addr, Imem_Req);
        end
        tick();
        total++;
        if (IF_ID_PC4 !== 32'h4 || IF_ID_Valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_first_ifid pc4=%h valid=%b want 00000004 1", IF_ID_PC4, IF_ID_Valid);
        end
        $display("reset_in_drain: pc4=%h", IF_ID_PC4);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall_hold();
        test_redirect_drain();
        test_redirect_hold();
        test_wrap();
        test_random();
        test_reset_in_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
